perm_layer_engine: RTL and testbench

//  Parametrised, iterative PRESENT-style bit-permutation engine. Generalises the fixed 64-bit pLayer.
//  - Any WIDTH that is a multiple of 4.
//  - Forward or inverse direction per transaction.
//  - Applies the layer a programmable number of times, one application per clock.

---
 rtl/perm_layer_engine_if.sv | 26 ++
 rtl/perm_layer_engine.sv | 104 ++++++++++
 tb/tb_perm_layer_engine.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perm_layer_engine_if.sv
// Valid/ready block interface for perm_layer_engine; "slave" is the engine side,
// "master" the producer/consumer side.
interface perm_layer_engine_if #(
    parameter int WIDTH = 64,
    parameter int RW    = 5
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic [RW-1:0]    rounds_i;
    logic             mode_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             busy_o;

    modport slave (
        input  valid_i, data_i, rounds_i, mode_i, ready_i,
        output ready_o, valid_o, data_o, busy_o
    );

    modport master (
        output valid_i, data_i, rounds_i, mode_i, ready_i,
        input  ready_o, valid_o, data_o, busy_o
    );
endinterface

// File: rtl/perm_layer_engine.sv
// Iterative PRESENT-style bit-permutation engine, one layer application per clock.
// Define PERM_INV_EN to build the inverse mapping (mode_i=1 selects P^-1).
module perm_layer_engine #(
    parameter int WIDTH = 64,
    parameter int RW    = 5
) (
    input logic                clk_i,
    input logic                rst_n_i,
    perm_layer_engine_if.slave bus
);
    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t             cur, nxt;
    logic [WIDTH-1:0] state_q;
    logic [RW-1:0]    count_q;
    logic [WIDTH-1:0] fwd;
    logic [WIDTH-1:0] step;
    logic             accept;

    // Pure wiring: every index below is an elaboration-time constant.
    for (genvar i = 0; i < M; i++) begin : g_fwd
        assign fwd[(i * (WIDTH / 4)) % M] = state_q[i];
    end
    assign fwd[M] = state_q[M];

`ifdef PERM_INV_EN
    logic [WIDTH-1:0] inv;
    logic             mode_q;

    for (genvar j = 0; j < M; j++) begin : g_inv
        assign inv[(4 * j) % M] = state_q[j];
    end
    assign inv[M] = state_q[M];
    assign step   = mode_q ? inv : fwd;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q <= 1'b0;
        end else if (accept) begin
            mode_q <= bus.mode_i;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode_i;
    assign step        = fwd;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt         = cur;
        accept      = 1'b0;
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        bus.busy_o  = 1'b0;
        case (cur)
            IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.valid_i) begin
                    accept = 1'b1;
                    nxt    = (bus.rounds_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                bus.busy_o = 1'b1;
                if (count_q == RW'(1)) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                bus.busy_o  = 1'b1;
                bus.valid_o = 1'b1;
                if (bus.ready_i) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= '0;
            count_q <= '0;
        end else if (accept) begin
            state_q <= bus.data_i;
            count_q <= bus.rounds_i;
        end else if (cur == RUN) begin
            state_q <= step;
            count_q <= count_q - RW'(1);
        end
    end

    assign bus.data_o = state_q;
endmodule

// File: tb/tb_perm_layer_engine.sv
// Directed bench for perm_layer_engine at WIDTH=64, RW=5 with hand-computed vectors.
module tb_perm_layer_engine;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    perm_layer_engine_if #(.WIDTH(64), .RW(5)) bus ();

    perm_layer_engine #(.WIDTH(64), .RW(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one block, then scrambles inputs so later changes are proven harmless.
    // Returns with the engine in DONE (or after a 100-cycle timeout).
    task automatic do_txn(input logic [63:0] d, input logic [4:0] r, input logic m,
                          output logic [63:0] got, output int lat);
        bus.valid_i  = 1'b1;
        bus.data_i   = d;
        bus.rounds_i = r;
        bus.mode_i   = m;
        @(posedge clk);
        #1;
        bus.valid_i  = 1'b0;
        bus.data_i   = '1;
        bus.rounds_i = 5'd7;
        bus.mode_i   = ~m;
        lat = 1;
        while (!bus.valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = bus.data_o;
    endtask

    task automatic release_result();
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.data_o !== 64'h0) begin
            failures++;
            $display("FAIL reset: ready=%b valid=%b busy=%b data=%h required 1 0 0 0",
                     bus.ready_o, bus.valid_o, bus.busy_o, bus.data_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_forward();
        logic [63:0] got;
        int          lat;
        logic [63:0] vin [4]  = '{64'h2, 64'h2, 64'hDEAD_BEEF_0123_4567, 64'h4};
        logic [4:0]  rin [4]  = '{5'd1, 5'd2, 5'd3, 5'd1};
        logic [63:0] vexp [4] = '{64'h0000_0000_0001_0000, 64'h10, 64'hDEAD_BEEF_0123_4567,
                                  64'h0000_0001_0000_0000};
        for (int k = 0; k < 4; k++) begin
            do_txn(vin[k], rin[k], 1'b0, got, lat);
            checks++;
            if (got !== vexp[k]) begin
                failures++;
                $display("FAIL fwd_data[%0d]: got %h required %h", k, got, vexp[k]);
            end
            checks++;
            if (lat !== int'(rin[k]) + 1) begin
                failures++;
                $display("FAIL fwd_latency[%0d]: got %0d required %0d", k, lat, int'(rin[k]) + 1);
            end
            release_result();
            checks++;
            if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
                failures++;
                $display("FAIL fwd_release[%0d]: valid=%b ready=%b required 0 1", k, bus.valid_o, bus.ready_o);
            end
        end
    endtask

    task automatic test_passthrough();
        logic [63:0] got;
        int          lat;
        do_txn(64'hDEAD_BEEF_0123_4567, 5'd0, 1'b0, got, lat);
        checks++;
        if (got !== 64'hDEAD_BEEF_0123_4567) begin
            failures++;
            $display("FAIL pass_data: got %h required deadbeef01234567", got);
        end
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL pass_latency: got %0d required 1", lat);
        end
        release_result();
    endtask

    task automatic test_max_rounds();
        logic [63:0] got;
        int          lat;
        // 31 rounds = 10 full orbits of order 3 plus one step
        do_txn(64'h2, 5'd31, 1'b0, got, lat);
        checks++;
        if (got !== 64'h0000_0000_0001_0000) begin
            failures++;
            $display("FAIL max_data: got %h required 0000000000010000", got);
        end
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("FAIL max_latency: got %0d required 32", lat);
        end
        release_result();
    endtask

`ifdef PERM_INV_EN
    task automatic test_inverse();
        logic [63:0] got;
        int          lat;
        logic [63:0] vin [3]  = '{64'h0000_0000_0001_0000, 64'h8000_0000_0000_0001, 64'h10};
        logic [4:0]  rin [3]  = '{5'd1, 5'd5, 5'd1};
        logic [63:0] vexp [3] = '{64'h2, 64'h8000_0000_0000_0001, 64'h0000_0000_0001_0000};
        for (int k = 0; k < 3; k++) begin
            do_txn(vin[k], rin[k], 1'b1, got, lat);
            checks++;
            if (got !== vexp[k]) begin
                failures++;
                $display("FAIL inv_data[%0d]: got %h required %h", k, got, vexp[k]);
            end
            release_result();
        end
    endtask
`else
    task automatic test_mode_ignored();
        logic [63:0] got;
        int          lat;
        do_txn(64'h2, 5'd1, 1'b1, got, lat);
        checks++;
        if (got !== 64'h0000_0000_0001_0000) begin
            failures++;
            $display("FAIL mode_ignored: got %h required 0000000000010000", got);
        end
        release_result();
    endtask
`endif

    task automatic test_backpressure();
        logic [63:0] got;
        int          lat;
        do_txn(64'h2, 5'd1, 1'b0, got, lat);
        bus.valid_i  = 1'b1;
        bus.data_i   = 64'h1234_5678_9ABC_DEF0;
        bus.rounds_i = 5'd0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b1 ||
                bus.data_o !== 64'h0000_0000_0001_0000) begin
                failures++;
                $display("FAIL backpressure[%0d]: valid=%b ready=%b busy=%b data=%h required 1 0 1 0000000000010000",
                         c, bus.valid_o, bus.ready_o, bus.busy_o, bus.data_o);
            end
        end
        bus.valid_i = 1'b0;
        release_result();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: valid=%b ready=%b busy=%b required 0 1 0",
                     bus.valid_o, bus.ready_o, bus.busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int valids  = 0;
        bus.valid_i  = 1'b1;
        bus.data_i   = 64'h2;
        bus.rounds_i = 5'd1;
        bus.mode_i   = 1'b0;
        bus.ready_i  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus.ready_o) accepts++;
            if (bus.valid_o) begin
                valids++;
                checks++;
                if (bus.data_o !== 64'h0000_0000_0001_0000) begin
                    failures++;
                    $display("FAIL b2b_data: got %h required 0000000000010000", bus.data_o);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        checks++;
        if (accepts !== 4 || valids !== 4) begin
            failures++;
            $display("FAIL b2b_throughput: accepts=%0d results=%0d required 4 4", accepts, valids);
        end
        while (!bus.ready_o) begin
            release_result();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] got;
        int          lat;
        bus.valid_i  = 1'b1;
        bus.data_i   = 64'hFFFF_0000_FFFF_0000;
        bus.rounds_i = 5'd20;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy: got %b required 1", bus.busy_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.data_o !== 64'h0) begin
            failures++;
            $display("FAIL midrun_reset: ready=%b valid=%b busy=%b data=%h required 1 0 0 0",
                     bus.ready_o, bus.valid_o, bus.busy_o, bus.data_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(64'h2, 5'd2, 1'b0, got, lat);
        checks++;
        if (got !== 64'h10 || lat !== 3) begin
            failures++;
            $display("FAIL post_reset_txn: data=%h lat=%0d required 0000000000000010 3", got, lat);
        end
        release_result();
    endtask

    initial begin
        rst_n        = 1'b1;
        bus.valid_i  = 1'b0;
        bus.data_i   = '0;
        bus.rounds_i = '0;
        bus.mode_i   = 1'b0;
        bus.ready_i  = 1'b0;
        #3;
        test_reset();
        test_forward();
        test_passthrough();
        test_max_rounds();
`ifdef PERM_INV_EN
        test_inverse();
`else
        test_mode_ignored();
`endif
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
